// File: rtl/hl_write_arbiter.sv
// hl_write_arbiter: round-robin arbiter sharing one high/low split register between two writers and a clear source.
// Define HL_MERGE_EN to co-grant two writers whose half masks are disjoint.
module hl_write_arbiter #(
  parameter int N = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       mask0,
  input  logic [N-1:0]     data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [1:0]       mask1,
  input  logic [N-1:0]     data1,
  output logic             ack1,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [N/2-1:0]   inh,
  output logic [N/2-1:0]   inl,
  output logic             loadh,
  output logic             loadl,
  output logic             clear,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);
  localparam int H = N / 2;
  logic real0, real1, merge, go, g0, g1;
  logic ptr_q, ptr_d, loadh_q, loadh_d, loadl_q, loadl_d, clear_q, clear_d;
  logic [H-1:0] inh_q, inh_d, inl_q, inl_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    real0 = req0 & (|mask0);
    real1 = req1 & (|mask1);
`ifdef HL_MERGE_EN
    merge = real0 & real1 & ~(|(mask0 & mask1));
`else
    merge = 1'b0;
`endif
    go = ~reset & ~clr_req;
    g0 = go & real0 & (~real1 | merge | ~ptr_q);
    g1 = go & real1 & (~real0 | merge | ptr_q);
    // null requests carry nothing to write, so they are acked without a grant
    ack0 = g0 | (go & req0 & ~(|mask0));
    ack1 = g1 | (go & req1 & ~(|mask1));
    clr_ack = ~reset & clr_req;
    loadh_d = (g0 & mask0[1]) | (g1 & mask1[1]);
    loadl_d = (g0 & mask0[0]) | (g1 & mask1[0]);
    clear_d = clr_ack;
    inh_d = (g0 & mask0[1]) ? data0[N-1:H] : (g1 & mask1[1]) ? data1[N-1:H] : inh_q;
    inl_d = (g0 & mask0[0]) ? data0[H-1:0] : (g1 & mask1[0]) ? data1[H-1:0] : inl_q;
    ptr_d = (g0 ^ g1) ? g0 : ptr_q;
    cnt0_d = (g0 && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d = (g1 && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
      loadh_q <= 1'b0;
      loadl_q <= 1'b0;
      clear_q <= 1'b0;
      inh_q <= '0;
      inl_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      loadh_q <= loadh_d;
      loadl_q <= loadl_d;
      clear_q <= clear_d;
      inh_q <= inh_d;
      inl_q <= inl_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign inh = inh_q;
  assign inl = inl_q;
  assign loadh = loadh_q;
  assign loadl = loadl_q;
  assign clear = clear_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_hl_write_arbiter.sv
// tb_hl_write_arbiter: scoreboard bench for hl_write_arbiter (N=16, CNT_W=2); follows HL_MERGE_EN if defined.
module tb_hl_write_arbiter;
  logic clk = 1'b0;
  logic reset, req0, req1, clr_req;
  logic [1:0] mask0, mask1;
  logic [15:0] data0, data1;
  logic ack0, ack1, clr_ack, loadh, loadl, clear;
  logic [7:0] inh, inl;
  logic [1:0] grant_cnt0, grant_cnt1;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic rst; logic r0; logic [1:0] m0; logic [15:0] d0;
    logic r1; logic [1:0] m1; logic [15:0] d1; logic clr;
    logic [2:0] acks; logic lh; logic ll; logic cl;
    logic [7:0] ih; logic [7:0] il; logic [1:0] c0; logic [1:0] c1;
  } row_t;
  typedef struct { logic [22:0] v; string nm; } exp_t;
  exp_t sb[$];
  exp_t e;
  hl_write_arbiter #(.N(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .mask0(mask0), .data0(data0), .ack0(ack0),
    .req1(req1), .mask1(mask1), .data1(data1), .ack1(ack1),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .inh(inh), .inl(inl), .loadh(loadh), .loadl(loadl), .clear(clear),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({loadh, loadl, clear, inh, inl, grant_cnt0, grant_cnt1} !== e.v) begin
        errors++;
        $display("FAIL %s outputs {lh,ll,cl,inh,inl,c0,c1} got %h exp %h", e.nm,
                 {loadh, loadl, clear, inh, inl, grant_cnt0, grant_cnt1}, e.v);
      end
    end
  end
  task automatic drive(input row_t r);
    reset = r.rst; req0 = r.r0; mask0 = r.m0; data0 = r.d0;
    req1 = r.r1; mask1 = r.m1; data1 = r.d1; clr_req = r.clr;
  endtask
  task automatic test_reset;
    row_t rows[$] = '{
      '{'1,'1,2'b11,16'hFFFF,'1,2'b11,16'hFFFF,'1,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'1,'1,2'b11,16'hFFFF,'1,2'b11,16'hFFFF,'1,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL reset row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("reset row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_single;
    row_t rows[$] = '{
      '{'0,'1,2'b10,16'hAB00,'0,2'b00,16'h0000,'0,3'b100,'1,'0,'0,8'hAB,8'h00,2'd1,2'd0},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'hAB,8'h00,2'd1,2'd0}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL single row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("single row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_round_robin;
    row_t rows[$] = '{
      '{'1,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'0,'1,2'b11,16'h1111,'1,2'b11,16'h2222,'0,3'b100,'1,'1,'0,8'h11,8'h11,2'd1,2'd0},
      '{'0,'0,2'b00,16'h0000,'1,2'b11,16'h2222,'0,3'b010,'1,'1,'0,8'h22,8'h22,2'd1,2'd1},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h22,8'h22,2'd1,2'd1},
      '{'0,'1,2'b11,16'h1111,'1,2'b11,16'h2222,'0,3'b100,'1,'1,'0,8'h11,8'h11,2'd2,2'd1},
      '{'0,'0,2'b00,16'h0000,'1,2'b11,16'h2222,'0,3'b010,'1,'1,'0,8'h22,8'h22,2'd2,2'd2}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL round_robin row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("round_robin row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_clear;
    row_t rows[$] = '{
      '{'0,'1,2'b01,16'h0055,'0,2'b00,16'h0000,'1,3'b001,'0,'0,'1,8'h22,8'h22,2'd2,2'd2},
      '{'0,'1,2'b01,16'h0055,'0,2'b00,16'h0000,'0,3'b100,'0,'1,'0,8'h22,8'h55,2'd3,2'd2},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h22,8'h55,2'd3,2'd2}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL clear row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("clear row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_disjoint;
`ifdef HL_MERGE_EN
    row_t rows[$] = '{
      '{'1,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'0,'1,2'b10,16'hC300,'1,2'b01,16'h003C,'0,3'b110,'1,'1,'0,8'hC3,8'h3C,2'd1,2'd1},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'hC3,8'h3C,2'd1,2'd1}};
`else
    row_t rows[$] = '{
      '{'1,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'0,'1,2'b10,16'hC300,'1,2'b01,16'h003C,'0,3'b100,'1,'0,'0,8'hC3,8'h00,2'd1,2'd0},
      '{'0,'0,2'b00,16'h0000,'1,2'b01,16'h003C,'0,3'b010,'0,'1,'0,8'hC3,8'h3C,2'd1,2'd1},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'hC3,8'h3C,2'd1,2'd1}};
`endif
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL disjoint row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("disjoint row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_null;
    row_t rows[$] = '{
      '{'0,'1,2'b00,16'hFFFF,'1,2'b00,16'hFFFF,'0,3'b110,'0,'0,'0,8'hC3,8'h3C,2'd1,2'd1},
      '{'0,'1,2'b00,16'hFFFF,'1,2'b11,16'h5A5A,'0,3'b110,'1,'1,'0,8'h5A,8'h5A,2'd1,2'd2},
      '{'0,'1,2'b00,16'hFFFF,'0,2'b00,16'h0000,'1,3'b001,'0,'0,'1,8'h5A,8'h5A,2'd1,2'd2},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h5A,8'h5A,2'd1,2'd2}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL null row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("null row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_saturation;
    row_t rows[$] = '{
      '{'1,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'0,'1,2'b11,16'h0101,'0,2'b00,16'h0000,'0,3'b100,'1,'1,'0,8'h01,8'h01,2'd1,2'd0},
      '{'0,'1,2'b11,16'h0202,'0,2'b00,16'h0000,'0,3'b100,'1,'1,'0,8'h02,8'h02,2'd2,2'd0},
      '{'0,'1,2'b11,16'h0303,'0,2'b00,16'h0000,'0,3'b100,'1,'1,'0,8'h03,8'h03,2'd3,2'd0},
      '{'0,'1,2'b11,16'h0404,'0,2'b00,16'h0000,'0,3'b100,'1,'1,'0,8'h04,8'h04,2'd3,2'd0},
      '{'0,'1,2'b11,16'h0505,'0,2'b00,16'h0000,'0,3'b100,'1,'1,'0,8'h05,8'h05,2'd3,2'd0},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h05,8'h05,2'd3,2'd0}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL saturation row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("saturation row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  task automatic test_reset_after_grant;
    row_t rows[$] = '{
      '{'0,'1,2'b11,16'h7777,'1,2'b11,16'h8888,'0,3'b010,'1,'1,'0,8'h88,8'h88,2'd3,2'd1},
      '{'1,'1,2'b11,16'h7777,'1,2'b11,16'h8888,'0,3'b000,'0,'0,'0,8'h00,8'h00,2'd0,2'd0},
      '{'0,'1,2'b11,16'h7777,'1,2'b11,16'h8888,'0,3'b100,'1,'1,'0,8'h77,8'h77,2'd1,2'd0},
      '{'0,'0,2'b00,16'h0000,'0,2'b00,16'h0000,'0,3'b000,'0,'0,'0,8'h77,8'h77,2'd1,2'd0}};
    foreach (rows[i]) begin
      drive(rows[i]); #1;
      checks++;
      if ({ack0, ack1, clr_ack} !== rows[i].acks) begin
        errors++; $display("FAIL reset_after_grant row%0d acks got %b exp %b", i, {ack0, ack1, clr_ack}, rows[i].acks);
      end
      sb.push_back('{rows[i][22:0], $sformatf("reset_after_grant row%0d", i)});
      @(posedge clk); #2;
    end
  endtask
  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; clr_req = 1'b0;
    mask0 = 2'b00; mask1 = 2'b00; data0 = 16'h0; data1 = 16'h0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_disjoint();
    test_null();
    test_saturation();
    test_reset_after_grant();
    @(posedge clk); #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
